apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB master that turns simple valid/ready command requests from a host-side agent (debug bridge, CPU shim or testbench sequencer) into APB transfers on the timer's `tim_*` slave port, and returns the read data and error as a response. It sits directly upstream of the timer and owns `tim_psel`, `tim_penable`, `tim_pwrite`, `tim_paddr`, `tim_pwdata` and `tim_pstrb`. It carries one transfer at a time, has an optional PREADY timeout, and holds the response until the requester takes it.

## Interface
- ADDR_W, 12, APB address width; matches `tim_paddr`.
- DATA_W, 32, APB data width; a multiple of 8.
- TIMEOUT, 16, maximum ACCESS cycles to wait for PREADY; must be ≥ 2.

Ports:
- sys_clk  in  1  single clock; all state updates on the rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted this cycle when high together with `cmd_valid`.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 on writes.
- rsp_err  out  1  PSLVERR was sampled, or a timeout occurred.
- rsp_timeout  out  1  the transfer was aborted by timeout.
- tim_psel, tim_penable, tim_pwrite  out  1  APB control.
- tim_paddr  out  ADDR_W  APB address.
- tim_pwdata  out  DATA_W  APB write data.
- tim_pstrb  out  DATA_W/8  APB strobes.
- tim_prdata  in  DATA_W  APB read data.
- tim_pready  in  1  APB ready.
- tim_pslverr  in  1  APB error.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS and RESP.
- IDLE: `cmd_ready`=1.
  - On `cmd_valid` the block registers write, addr, wdata and strb, then moves to SETUP.
  - For reads the registered strb is forced to 0 and wdata to 0.
- SETUP: `psel`=1 and `penable`=0 for exactly one cycle, then the FSM moves to ACCESS.
- ACCESS: `psel`=1 and `penable`=1.
  - On an edge with `tim_pready`=1, the block captures `tim_prdata` (reads only; writes store 0) and `tim_pslverr` into the response registers, then moves to RESP.
- RESP: `rsp_valid`=1 and `psel`/`penable`=0.
  - On `rsp_ready`=1 the FSM moves to IDLE.
  - Response registers hold their value until the next capture.
- `cmd_ready` = (state==IDLE), decoded from the state register. No command is accepted in any other state.
- `tim_paddr`, `tim_pwrite`, `tim_pwdata` and `tim_pstrb` stay stable from SETUP through the last ACCESS cycle. In IDLE and RESP they hold their last value.
- `tim_pslverr` and `tim_prdata` are ignored outside the ACCESS-and-PREADY edge.
- Reset, including reset mid-transfer, acts immediately and asynchronously:
  - state goes to IDLE;
  - every output goes to 0 except `cmd_ready`, which goes to 1 only after reset is released (in IDLE).
  - An in-flight transfer is dropped and no response is produced.

## Timing
- Accept edge T0 → SETUP in cycle T1 → ACCESS from T2.
- With PREADY high in T2, `rsp_valid` rises in T3: command-to-response latency is 3 cycles.
- Each cycle of `tim_pready`=0 in ACCESS adds 1 cycle.
- With `rsp_ready` held high, the FSM is back in IDLE at T4. Peak throughput is one transfer per 4 cycles.
- `rsp_valid` and the response fields change only on the RESP entry edge.
- If `cmd_valid` is asserted while in RESP, it is accepted no earlier than the first IDLE cycle.
- `rsp_valid` stays asserted indefinitely while `rsp_ready`=0. The APB bus stays idle (`psel`=0) throughout.

## Configuration
- Macro: `APB_CMD_MASTER_TIMEOUT_EN`.
- Defined:
  - A wait counter of width $clog2(TIMEOUT)+1 clears on SETUP entry and increments each ACCESS cycle with `tim_pready`=0.
  - When the counter equals TIMEOUT-1 and `tim_pready`=0, the FSM leaves ACCESS to RESP. That is TIMEOUT ACCESS cycles in total.
  - On that exit: `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, and `psel`/`penable` drop on the same edge.
  - If PREADY arrives in that final cycle, it wins: normal completion, `rsp_timeout`=0.
- Undefined: no counter is built, ACCESS waits forever, and `rsp_timeout` is tied to 0.

## Structure
- Package `apb_cmd_master_pkg` holds:
  - the state enum (IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - default ADDR_W, DATA_W and TIMEOUT constants.
- Optional sub-module `apb_wait_timer` contains the timeout counter. It is instantiated only under the macro and has inputs clear/count and output expired.

## Test plan
- Write 0x0000_00A5 to 0x004 with strb 0xF and PREADY tied high → `psel` high T1–T2, `penable` high T2 only, `pwdata`=0x0000_00A5, `rsp_valid` in T3 with `rsp_err`=0 and `rsp_rdata`=0.
- Read 0x010 with slave returning 0x1234_5678 after 3 wait states → `pstrb`=0, `pwdata`=0, ACCESS lasts 4 cycles, `rsp_rdata`=0x1234_5678, latency 6 cycles.
- Write with PSLVERR=1 on the ready edge → `rsp_err`=1, `rsp_timeout`=0.
- Macro defined, TIMEOUT=16, PREADY held low → ACCESS lasts exactly 16 cycles, then `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. Same case with PREADY rising in ACCESS cycle 16 → normal completion.
- Hold `rsp_ready`=0 for 10 cycles while `cmd_valid`=1 → `rsp_valid` steady, `cmd_ready`=0, `psel`=0. The second command is accepted one cycle after `rsp_ready` rises.
- Assert `sys_rst` during ACCESS → `psel`, `penable` and `rsp_valid` go to 0 without waiting for a clock edge. After release the block is in IDLE with `cmd_ready`=1 and no response is issued.

Source files
------------

// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: shared types and defaults for the APB command master.
//   state_t          : FSM encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
//   DEF_ADDR_W/DATA_W: default APB address / data widths
//   DEF_TIMEOUT      : default PREADY wait limit in ACCESS cycles
package apb_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS cycles spent waiting for PREADY.
// Ports:
//   clk, rst : clock, async active-high reset
//   clear    : zero the counter (takes priority over count)
//   count    : increment by one this cycle
//   expired  : counter has reached TIMEOUT-1 (last allowed wait cycle)
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (clear) cnt <= '0;
        else if (count) cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns valid/ready host commands into single APB transfers
// on the timer's tim_* slave port and returns rdata/err as a held response.
// Optional feature macro: APB_CMD_MASTER_TIMEOUT_EN (PREADY wait timeout).
// Ports:
//   sys_clk, sys_rst           : clock, async active-high reset
//   cmd_valid/ready, cmd_write, cmd_addr, cmd_wdata, cmd_strb : request
//   rsp_valid/ready, rsp_rdata, rsp_err, rsp_timeout          : response
//   tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata,
//   tim_pstrb, tim_prdata, tim_pready, tim_pslverr            : APB master
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                tim_psel,
    output logic                tim_penable,
    output logic                tim_pwrite,
    output logic [ADDR_W-1:0]   tim_paddr,
    output logic [DATA_W-1:0]   tim_pwdata,
    output logic [DATA_W/8-1:0] tim_pstrb,
    input  logic [DATA_W-1:0]   tim_prdata,
    input  logic                tim_pready,
    input  logic                tim_pslverr
);
    state_t state, state_nxt;
    logic   accept, capture, tmo_hit, expired;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                accept    = 1'b1;
                state_nxt = SETUP;
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                // PREADY wins over an expiring timer in the same cycle
                if (tim_pready) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Held low during reset so no command can be seen as accepted then.
    assign cmd_ready   = (state == IDLE) && !sys_rst;
    assign tim_psel    = (state == SETUP) || (state == ACCESS);
    assign tim_penable = (state == ACCESS);
    assign rsp_valid   = (state == RESP);

    // Request registers double as the APB address/data phase drivers;
    // they only change on the accept edge, so they stay stable through
    // SETUP/ACCESS and hold their value in IDLE/RESP.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tim_pwrite <= 1'b0;
            tim_paddr  <= '0;
            tim_pwdata <= '0;
            tim_pstrb  <= '0;
        end else if (accept) begin
            tim_pwrite <= cmd_write;
            tim_paddr  <= cmd_addr;
            tim_pwdata <= cmd_write ? cmd_wdata : '0;
            tim_pstrb  <= cmd_write ? cmd_strb  : '0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (capture) begin
            rsp_rdata <= tim_pwrite ? '0 : tim_prdata;
            rsp_err   <= tim_pslverr;
        end else if (tmo_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
        end
    end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    logic tmo_q;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clear   (accept),
        .count   ((state == ACCESS) && !tim_pready),
        .expired (expired)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)      tmo_q <= 1'b0;
        else if (capture) tmo_q <= 1'b0;
        else if (tmo_hit) tmo_q <= 1'b1;
    end

    assign rsp_timeout = tmo_q;
`else
    assign expired     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: stimulus thread drives commands and a
// slave model, pushes expected responses; a monitor pops and compares each
// accepted response.
module tb_apb_cmd_master;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_strb = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          tim_psel, tim_penable, tim_pwrite;
    logic [AW-1:0] tim_paddr;
    logic [DW-1:0] tim_pwdata, tim_prdata = '0;
    logic [3:0]    tim_pstrb;
    logic          tim_pready = 1'b0, tim_pslverr = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q[$];   // {rdata, err, timeout}

    always #5 sys_clk = ~sys_clk;

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Monitor: one comparison per response handshake.
    always @(negedge sys_clk) begin
        if (!sys_rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {30'd0, rsp_rdata, rsp_err, rsp_timeout}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("rsp", {30'd0, rsp_rdata, rsp_err, rsp_timeout}, {30'd0, e});
            end
        end
    end

    // Issue one command (caller is just past a posedge with DUT in IDLE) and
    // play the slave: PREADY rises after `waits` wait cycles. Returns just
    // after the RESP entry edge.
    task automatic do_xfer(input string nm, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [3:0] st,
                           input int waits, input logic slverr,
                           input logic [DW-1:0] rd, input logic exp_to);
        logic [48:0] exp_bus;
        int cyc, nacc, exp_nacc;
        bit done, hold_ok;
        exp_q.push_back({(wr || exp_to) ? 32'd0 : rd, exp_to ? 1'b1 : slverr, exp_to});
        exp_bus  = {wr, addr, wr ? wd : 32'd0, wr ? st : 4'd0};
        exp_nacc = exp_to ? TO : waits + 1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        chk({nm, "_setup"}, {tim_psel, tim_penable}, 2'b10);
        hold_ok = ({tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb} === exp_bus);
        cyc = 1; nacc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(posedge sys_clk); #1;
            cyc++;
            if (rsp_valid) begin
                done = 1;
            end else if (tim_penable && tim_psel) begin
                nacc++;
                hold_ok &= ({tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb} === exp_bus);
                tim_pready  = (nacc > waits);
                tim_pslverr = tim_pready ? slverr : 1'b1;
                tim_prdata  = tim_pready ? rd : 32'hBAD0_BAD0;
            end
        end
        tim_pready = 1'b0; tim_pslverr = 1'b0; tim_prdata = '0;
        chk({nm, "_done"}, done, 1);
        chk({nm, "_apb_fields"}, hold_ok, 1);
        chk({nm, "_access_cycles"}, nacc, exp_nacc);
        chk({nm, "_latency"}, cyc, exp_nacc + 2);
        chk({nm, "_resp_bus_idle"}, {tim_psel, tim_penable, cmd_ready}, 3'b000);
    endtask

    task automatic back_to_idle(input string nm);
        @(posedge sys_clk); #1;
        chk({nm, "_idle"}, {cmd_ready, tim_psel, rsp_valid}, 3'b100);
    endtask

    initial begin
        bit held, quiet;
        // reset state
        #1;
        chk("reset_outputs", {cmd_ready, tim_psel, tim_penable, rsp_valid, rsp_err,
                              rsp_timeout, tim_pwrite, tim_paddr, rsp_rdata}, 0);
        @(negedge sys_clk); sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        chk("reset_release_ready", cmd_ready, 1);

        do_xfer("wr_a5", 1'b1, 12'h004, 32'h0000_00A5, 4'hF, 0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        back_to_idle("wr_a5");
        do_xfer("rd_wait3", 1'b0, 12'h010, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b0);
        back_to_idle("rd_wait3");
        do_xfer("wr_slverr", 1'b1, 12'h008, 32'h0BAD_F00D, 4'h5, 1, 1'b1, 32'h0, 1'b0);
        back_to_idle("wr_slverr");
        do_xfer("rd_slverr", 1'b0, 12'hFFC, 32'h0, 4'h0, 2, 1'b1, 32'h8765_4321, 1'b0);
        back_to_idle("rd_slverr");
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        do_xfer("tmo", 1'b0, 12'h0A0, 32'h0, 4'h0, 1000, 1'b0, 32'h1111_2222, 1'b1);
        back_to_idle("tmo");
        do_xfer("tmo_late_ready", 1'b0, 12'h0A4, 32'h0, 4'h0, TO - 1, 1'b0, 32'h3333_4444, 1'b0);
        back_to_idle("tmo_late_ready");
`endif

        // response backpressure with a second command pending
        rsp_ready = 1'b0;
        do_xfer("bp_rd", 1'b0, 12'h020, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h030;
        cmd_wdata = 32'h55AA_55AA; cmd_strb = 4'h3;
        held = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk); #1;
            held &= rsp_valid && !cmd_ready && !tim_psel && (rsp_rdata == 32'hCAFE_F00D);
        end
        chk("bp_hold", held, 1);
        rsp_ready = 1'b1;
        @(posedge sys_clk); #1;
        chk("bp_release_idle", {cmd_ready, tim_psel, rsp_valid}, 3'b100);
        do_xfer("bp_wr", 1'b1, 12'h030, 32'h55AA_55AA, 4'h3, 0, 1'b0, 32'h0, 1'b0);
        back_to_idle("bp_wr");

        // asynchronous reset during ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        @(posedge sys_clk); #1;
        chk("rst_pre_access", {tim_psel, tim_penable}, 2'b11);
        #2 sys_rst = 1'b1;
        #1;
        chk("rst_async", {tim_psel, tim_penable, rsp_valid, cmd_ready, tim_paddr}, 0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk); sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        chk("rst_after_ready", {cmd_ready, tim_psel}, 2'b10);
        quiet = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk); #1;
            quiet &= !rsp_valid && !tim_psel;
        end
        chk("rst_no_response", quiet, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
